// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types for the I2C master arbiter.
//   REQ_W           - width of one packed requester command
//   i2c_req_t       - {daddr[6:0], wen, addr[7:0], data[7:0]}
//   i2c_arb_state_t - arbiter FSM states
package i2c_pkg;

    localparam int REQ_W = 24;

    typedef struct packed {
        logic [6:0] daddr;
        logic       wen;
        logic [7:0] addr;
        logic [7:0] data;
    } i2c_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } i2c_arb_state_t;

endpackage

// File: rtl/i2c_arb_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_i - request vector
//   ptr_i - index of the last winner; search starts at ptr_i+1 (mod N)
//   idx_o - winning index (valid when vld_o)
//   vld_o - at least one request present
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    logic [IW-1:0] cand;

    function automatic logic [IW-1:0] wrap(input int v);
        int r;
        r = v % N;
        return r[IW-1:0];
    endfunction

    // Walk from the farthest offset down to ptr+1 so the nearest
    // requesting index is the last one written and therefore wins.
    always_comb begin
        idx_o = '0;
        cand  = '0;
        vld_o = |req_i;
        for (int i = N; i >= 1; i--) begin
            cand = wrap(int'(ptr_i) + i);
            if (req_i[cand]) idx_o = cand;
        end
    end

endmodule

// File: rtl/i2c_arb.sv
// i2c_arb: arbitrates N_REQ requesters onto one shared I2C master with
// exactly one transaction outstanding.
//   clk_i, rst_ni                    - clock, async active-low reset
//   req_val_i/req_i/req_rdy_o        - per-requester command channel
//   rsp_val_o/rsp_err_o/rsp_data_o   - response, rsp_val_o one-hot to grant
//   rsp_rdy_i                        - per-requester response accept
//   m_val_o/m_daddr_o/m_wen_o/
//   m_addr_o/m_data_o/m_rdy_i        - command side of the shared master
//   m_rsp_val_i/m_rsp_err_i/
//   m_rsp_data_i/m_rsp_rdy_o         - response side of the shared master
// Optional: define I2C_ARB_WDOG_EN to add a WDOG_CYCLES watchdog over
// ISSUE/WAIT that completes the transaction with err=1, data=0.
module i2c_arb
    import i2c_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int WDOG_CYCLES = 1048576
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [N_REQ-1:0]            req_val_i,
    input  logic [N_REQ-1:0][REQ_W-1:0] req_i,
    output logic [N_REQ-1:0]            req_rdy_o,
    output logic [N_REQ-1:0]            rsp_val_o,
    output logic                        rsp_err_o,
    output logic [7:0]                  rsp_data_o,
    input  logic [N_REQ-1:0]            rsp_rdy_i,
    output logic                        m_val_o,
    output logic [6:0]                  m_daddr_o,
    output logic                        m_wen_o,
    output logic [7:0]                  m_addr_o,
    output logic [7:0]                  m_data_o,
    input  logic                        m_rdy_i,
    input  logic                        m_rsp_val_i,
    input  logic                        m_rsp_err_i,
    input  logic [7:0]                  m_rsp_data_i,
    output logic                        m_rsp_rdy_o
);

    localparam int GW = $clog2(N_REQ);

    i2c_arb_state_t state_q, state_d;
    logic [GW-1:0]  ptr_q, grant_q;
    i2c_req_t       req_q;
    logic           err_q;
    logic [7:0]     data_q;

    logic [GW-1:0]  pick_idx;
    logic           pick_vld;
    logic           wdog_hit;

    rr_pick #(.N(N_REQ), .IW(GW)) u_pick (
        .req_i (req_val_i),
        .ptr_i (ptr_q),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

`ifdef I2C_ARB_WDOG_EN
    localparam int WCW = $clog2(WDOG_CYCLES + 1);
    logic [WCW-1:0] wdog_cnt_q;

    // Held at zero in IDLE, so it is cleared on every entry to ISSUE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                     wdog_cnt_q <= '0;
        else if (state_q == ST_IDLE)                     wdog_cnt_q <= '0;
        else if (state_q == ST_ISSUE || state_q == ST_WAIT) wdog_cnt_q <= wdog_cnt_q + 1'b1;
    end

    assign wdog_hit = (state_q == ST_ISSUE || state_q == ST_WAIT) &&
                      (wdog_cnt_q >= WCW'(WDOG_CYCLES - 1));
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_CYCLES;
    assign wdog_hit    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_vld) state_d = ST_ISSUE;
            // Timeout wins over a same-cycle accept: the request is dropped.
            ST_ISSUE: if (wdog_hit) state_d = ST_RESP;
                      else if (m_rdy_i) state_d = ST_WAIT;
            ST_WAIT:  if (m_rsp_val_i || wdog_hit) state_d = ST_RESP;
            ST_RESP:  if (rsp_rdy_i[grant_q]) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Transaction datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q   <= GW'(N_REQ - 1);
            grant_q <= '0;
            req_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            if (state_q == ST_IDLE && pick_vld) begin
                grant_q <= pick_idx;
                req_q   <= i2c_req_t'(req_i[pick_idx]);
            end
            if (state_q == ST_WAIT && m_rsp_val_i) begin
                err_q  <= m_rsp_err_i;
                data_q <= m_rsp_data_i;
            end else if (wdog_hit) begin
                err_q  <= 1'b1;
                data_q <= 8'h00;
            end
            if (state_q == ST_RESP && rsp_rdy_i[grant_q]) ptr_q <= grant_q;
        end
    end

    // Outputs
    always_comb begin
        req_rdy_o   = '0;
        rsp_val_o   = '0;
        rsp_err_o   = 1'b0;
        rsp_data_o  = 8'h00;
        m_val_o     = 1'b0;
        m_rsp_rdy_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_rdy_o[pick_idx] = pick_vld;
                m_rsp_rdy_o         = 1'b1;   // drain stray master responses
            end
            ST_ISSUE: m_val_o = 1'b1;
            ST_WAIT:  m_rsp_rdy_o = 1'b1;
            ST_RESP: begin
                rsp_val_o[grant_q] = 1'b1;
                rsp_err_o          = err_q;
                rsp_data_o         = data_q;
            end
            default: ;
        endcase
    end

    assign m_daddr_o = req_q.daddr;
    assign m_wen_o   = req_q.wen;
    assign m_addr_o  = req_q.addr;
    assign m_data_o  = req_q.data;

endmodule
